// File: rtl/j1_soc.sv
// j1_soc: J1-style 16-bit stack CPU with unified 8Kx16 RAM, an LED register,
// a transmit-only console UART and a full-duplex Bluetooth UART.
module j1_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] din,
    output logic       busy,
    output logic       tx
);
    logic [9:0]  sh;
    logic [15:0] cnt;
    logic [3:0]  bitn;
    assign tx = busy ? sh[0] : 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            sh   <= '1;
            cnt  <= '0;
            bitn <= '0;
        end else if (!busy) begin
            if (wr) begin
                busy <= 1'b1;
                sh   <= {1'b1, din, 1'b0};
                cnt  <= '0;
                bitn <= '0;
            end
        end else if (cnt == 16'(CLKS_PER_BIT - 1)) begin
            cnt  <= '0;
            sh   <= {1'b1, sh[9:1]};
            bitn <= bitn + 4'd1;
            busy <= bitn != 4'd9;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end
endmodule

module j1_uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd,
    output logic       valid,
    output logic [7:0] dout
);
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
    logic        s1, s2, s3;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic [2:0]  bitn;
    logic [7:0]  sh;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
            st <= S_IDLE;
            cnt <= '0;
            bitn <= '0;
            sh <= '0;
            valid <= 1'b0;
            dout <= '0;
        end else begin
            if (rx == 1'b0) s1 <= 1'b0;
            else s1 <= 1'b1;
            s2 <= s1;
            s3 <= s2;
            cnt <= cnt + 16'd1;
            if (rd) valid <= 1'b0;
            case (st)
                S_IDLE: begin
                    cnt <= '0;
                    if (s3 && !s2) st <= S_START;
                end
                S_START: if (cnt == 16'(CLKS_PER_BIT / 2 - 1)) begin
                    cnt <= '0;
                    bitn <= '0;
                    st <= s2 ? S_IDLE : S_DATA;
                end
                S_DATA: if (cnt == 16'(CLKS_PER_BIT - 1)) begin
                    cnt <= '0;
                    sh <= {s2, sh[7:1]};
                    bitn <= bitn + 3'd1;
                    if (bitn == 3'd7) st <= S_STOP;
                end
                default: if (cnt == 16'(CLKS_PER_BIT - 1)) begin
                    st <= S_IDLE;
                    if (s2) begin
                        dout <= sh;
                        valid <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

module j1_soc #(
    parameter string MEM_INIT     = "j1.hex",
    parameter int    CLKS_PER_BIT = 434
) (
    output logic uart_tx,
    output logic ledout,
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    output logic bt_tx,
    input  logic bt_rx
);
    logic [15:0] ram [0:8191];
    logic [15:0] dstack [0:15];
    logic [15:0] rstack [0:15];
    logic [12:0] pc, pc_n, pc_p1;
    logic [15:0] t, t_n, n, r, insn, alu, io_rd, rwd, led;
    logic [3:0]  dsp, dsp_n, rsp, rsp_n;
    logic [7:0]  bt_data;
    logic        is_alu, dwe, rwe, mem_we, bt_rd, con_busy, bt_busy, bt_valid;
    logic        unused;

    assign insn   = ram[pc];
    assign n      = dstack[dsp];
    assign r      = rstack[rsp];
    assign pc_p1  = pc + 13'd1;
    assign is_alu = insn[15:13] == 3'b011;
    assign mem_we = !sys_rst_i && is_alu && insn[5];
    assign bt_rd  = !sys_rst_i && is_alu && insn[11:8] == 4'd12 && t == 16'h6014;
    assign unused = insn[4];
    assign ledout = led[0];
    assign io_rd  = t[15:13] == 3'b000 ? ram[t[12:0]] :
                    t == 16'h6000 ? led :
                    t == 16'h6004 ? {15'd0, con_busy} :
                    t == 16'h6012 ? {14'd0, bt_valid, bt_busy} :
                    t == 16'h6014 ? {8'd0, bt_data} : 16'd0;

    always_comb begin
        case (insn[11:8])
            4'd0:    alu = t;
            4'd1:    alu = n;
            4'd2:    alu = t + n;
            4'd3:    alu = t & n;
            4'd4:    alu = t | n;
            4'd5:    alu = t ^ n;
            4'd6:    alu = ~t;
            4'd7:    alu = {16{n == t}};
            4'd8:    alu = {16{$signed(n) < $signed(t)}};
            4'd9:    alu = n >> t[3:0];
            4'd10:   alu = t - 16'd1;
            4'd11:   alu = r;
            4'd12:   alu = io_rd;
            4'd13:   alu = n << t[3:0];
            4'd14:   alu = {8'd0, dsp, rsp};
            default: alu = {16{n < t}};
        endcase
    end

    always_comb begin
        pc_n = pc_p1;
        t_n = t;
        dsp_n = dsp;
        rsp_n = rsp;
        dwe = 1'b0;
        rwe = 1'b0;
        rwd = t;
        if (insn[15]) begin
            t_n = {1'b0, insn[14:0]};
            dsp_n = dsp + 4'd1;
            dwe = 1'b1;
        end else begin
            case (insn[14:13])
                2'b00: pc_n = insn[12:0];
                2'b01: begin
                    t_n = n;
                    dsp_n = dsp - 4'd1;
                    pc_n = t == 16'd0 ? insn[12:0] : pc_p1;
                end
                2'b10: begin
                    rsp_n = rsp + 4'd1;
                    rwe = 1'b1;
                    rwd = {3'd0, pc_p1};
                    pc_n = insn[12:0];
                end
                default: begin
                    t_n = alu;
                    dsp_n = dsp + {{2{insn[1]}}, insn[1:0]};
                    rsp_n = rsp + {{2{insn[3]}}, insn[3:2]};
                    dwe = insn[7];
                    rwe = insn[6];
                    pc_n = insn[12] ? r[12:0] : pc_p1;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            pc <= '0;
            t <= '0;
            dsp <= '0;
            rsp <= '0;
            led <= '0;
        end else begin
            pc <= pc_n;
            t <= t_n;
            dsp <= dsp_n;
            rsp <= rsp_n;
            if (mem_we && t == 16'h6000) led <= n;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (dwe) dstack[dsp_n] <= t;
        if (rwe) rstack[rsp_n] <= rwd;
        if (mem_we && t[15:13] == 3'b000) ram[t[12:0]] <= n;
    end

    j1_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_con (
        .clk(sys_clk_i), .rst(sys_rst_i), .wr(mem_we && t == 16'h6002),
        .din(n[7:0]), .busy(con_busy), .tx(uart_tx)
    );
    j1_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bt_tx (
        .clk(sys_clk_i), .rst(sys_rst_i), .wr(mem_we && t == 16'h6010),
        .din(n[7:0]), .busy(bt_busy), .tx(bt_tx)
    );
    j1_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bt_rx (
        .clk(sys_clk_i), .rst(sys_rst_i), .rx(bt_rx), .rd(bt_rd),
        .valid(bt_valid), .dout(bt_data)
    );
endmodule

// File: tb/tb_j1_soc.sv
// tb_j1_soc: scoreboard bench for j1_soc; firmware images are poked into RAM
// while reset is held, expected results queue up as each image is written.
module tb_j1_soc;
    localparam logic [15:0] NOP = 16'h6000, INV = 16'h6600, DROP = 16'h6103, STORE = 16'h6123;
    localparam logic [15:0] FETCH = 16'h6C00, ADD = 16'h6203, AND = 16'h6303;
    localparam logic [15:0] RET = 16'h700C, DEPTH = 16'h6E81;
    logic clk = 1'b0, rst = 1'b1, lb = 1'b0, rx_drv = 1'b1;
    logic uart_tx, ledout, bt_tx, bt_rx;
    logic [15:0] exp_q [$];
    logic [9:0] frame;
    int checks = 0, failures = 0;
    // {op, invert-n flag, n, t}
    logic [39:0] cases [16] = '{
        40'h1_0_2222_0005, 40'h2_0_1234_4321, 40'h2_1_0000_0002, 40'h3_0_0FF0_3C3C,
        40'h4_0_0F00_00F0, 40'h5_0_5555_7FFF, 40'h6_0_0000_1234, 40'h7_0_0005_0005,
        40'h7_0_0005_0006, 40'h8_1_0000_0001, 40'hF_1_0000_0001, 40'h9_1_00FF_0004,
        40'hA_0_0000_0000, 40'hD_0_0001_000F, 40'hF_0_0003_7000, 40'h8_0_7000_0003
    };

    assign bt_rx = lb ? bt_tx : rx_drv;
    always #5 clk = ~clk;

    j1_soc #(.MEM_INIT(""), .CLKS_PER_BIT(4)) dut (
        .uart_tx(uart_tx), .ledout(ledout), .sys_clk_i(clk),
        .sys_rst_i(rst), .bt_tx(bt_tx), .bt_rx(bt_rx)
    );

    function automatic logic [15:0] lit(input logic [14:0] v);
        return {1'b1, v};
    endfunction

    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd1:    return a;
            4'd2:    return 16'(int'(a) + int'(b));
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return 16'hFFFF - b;
            4'd7:    return a == b ? 16'hFFFF : 16'h0000;
            4'd8:    return (int'(a) - (a[15] ? 65536 : 0)) < (int'(b) - (b[15] ? 65536 : 0)) ? 16'hFFFF : 16'h0000;
            4'd9:    return 16'(int'(a) / (1 << b[3:0]));
            4'd10:   return 16'(int'(b) + 65535);
            4'd13:   return 16'(int'(a) * (1 << b[3:0]));
            4'd15:   return int'(a) < int'(b) ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [15:0] got);
        logic [15:0] e;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = ~got;
        check(tag, got, e);
    endtask

    task automatic load(input int a, input logic [15:0] w);
        dut.ram[a] = w;
    endtask

    task automatic run_until(input logic [12:0] a, input int lim, input string tag);
        for (int i = 0; i < lim && dut.pc != a; i++) tick(1);
        check(tag, 16'(dut.pc), 16'(a));
    endtask

    initial begin
        // LED write and reset state
        load(0, lit(15'h1)); load(1, lit(15'h6000)); load(2, STORE); load(3, 16'h0003);
        tick(5);
        check("rst_uart_tx", 16'(uart_tx), 16'h1);
        check("rst_bt_tx", 16'(bt_tx), 16'h1);
        check("rst_ledout", 16'(ledout), 16'h0);
        check("rst_pc", 16'(dut.pc), 16'h0);
        check("rst_t", dut.t, 16'h0);
        exp_q.push_back(16'h1);
        exp_q.push_back(16'h1);
        rst = 1'b0;
        tick(4);
        pop_check("led_on", 16'(ledout));
        tick(20);
        pop_check("led_hold", 16'(ledout));
        rst = 1'b1;
        tick(2);
        check("led_cleared_by_rst", 16'(ledout), 16'h0);

        // Console TX of 0x41, then a reset mid-frame
        load(0, lit(15'h41)); load(1, lit(15'h6002)); load(2, STORE);
        load(3, lit(15'h6004)); load(4, FETCH); load(5, 16'h0005);
        frame = {1'b1, 8'h41, 1'b0};
        for (int j = 0; j < 10; j++) exp_q.push_back(16'(frame[j]));
        tick(3);
        rst = 1'b0;
        tick(3);
        for (int j = 0; j < 10; j++) begin
            tick(2);
            pop_check($sformatf("con_bit%0d", j), 16'(uart_tx));
            check($sformatf("con_busy%0d", j), 16'(dut.con_busy), 16'h1);
            tick(2);
        end
        check("con_status_read", dut.t, 16'h1);
        check("con_idle_pin", 16'(uart_tx), 16'h1);
        check("con_idle_busy", 16'(dut.con_busy), 16'h0);
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(9);
        check("con_mid_busy", 16'(dut.con_busy), 16'h1);
        rst = 1'b1;
        tick(1);
        check("con_abort_pin", 16'(uart_tx), 16'h1);
        check("con_abort_busy", 16'(dut.con_busy), 16'h0);

        // BT loopback: send 0x5A, poll rx valid, read and park it at 0x100
        lb = 1'b1;
        load(0, lit(15'h5A)); load(1, lit(15'h6010)); load(2, STORE); load(3, DROP);
        load(4, lit(15'h6012)); load(5, FETCH); load(6, lit(15'h2)); load(7, AND);
        load(8, 16'h2004); load(9, lit(15'h6014)); load(10, FETCH); load(11, lit(15'h100));
        load(12, STORE); load(13, lit(15'h6012)); load(14, FETCH); load(15, 16'h000F);
        exp_q.push_back(16'h005A);
        tick(5);
        rst = 1'b0;
        run_until(13'd15, 400, "bt_poll_done");
        tick(2);
        pop_check("bt_rx_byte", dut.ram[16'h100]);
        check("bt_status_after_read", dut.t, 16'h0);
        rst = 1'b1;
        lb = 1'b0;

        // Control flow: jz taken/not taken, call/return computing 3+4
        load(0, lit(15'h0)); load(1, 16'h2003); load(2, lit(15'h0BAD)); load(3, lit(15'h0));
        load(4, INV); load(5, 16'h2014); load(6, 16'h4010); load(7, DEPTH);
        load(8, lit(15'h200)); load(9, STORE); load(10, DROP); load(11, 16'h000B);
        load(16, lit(15'h3)); load(17, lit(15'h4)); load(18, ADD); load(19, RET); load(20, 16'h0014);
        tick(5);
        rst = 1'b0;
        run_until(13'd11, 200, "flow_done");
        check("flow_t", dut.t, 16'h0007);
        check("flow_dsp", 16'(dut.dsp), 16'h1);
        check("flow_rsp", 16'(dut.rsp), 16'h0);
        check("flow_depth", dut.ram[16'h200], 16'h0010);
        rst = 1'b1;

        // ALU table: each result is stored at 0x300+k
        foreach (cases[k]) begin
            int a;
            a = 7 * k;
            load(a, lit(cases[k][30:16]));
            load(a + 1, cases[k][32] ? INV : NOP);
            load(a + 2, lit(cases[k][14:0]));
            load(a + 3, {4'h6, cases[k][39:36], 8'h03});
            load(a + 4, 16'h8300 + 16'(k));
            load(a + 5, STORE);
            load(a + 6, DROP);
            exp_q.push_back(model(cases[k][39:36],
                cases[k][32] ? ~cases[k][31:16] : cases[k][31:16], cases[k][15:0]));
        end
        load(112, 16'd112);
        tick(5);
        rst = 1'b0;
        run_until(13'd112, 400, "alu_done");
        foreach (cases[k]) pop_check($sformatf("alu%0d_op%0d", k, cases[k][39:36]), dut.ram[16'h300 + k]);
        rst = 1'b1;

        // Undriven BT rx while firmware keeps reading rx data and counting
        rx_drv = 1'bx;
        load(0, lit(15'h0)); load(1, lit(15'h6014)); load(2, FETCH); load(3, ADD);
        load(4, lit(15'h1)); load(5, ADD); load(6, 16'h0001);
        tick(5);
        rst = 1'b0;
        tick(3001);
        check("nox_pc", 16'($isunknown(dut.pc)), 16'h0);
        check("nox_t", 16'($isunknown(dut.t)), 16'h0);
        check("undriven_count", dut.t, 16'd500);
        check("undriven_valid", 16'(dut.bt_valid), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
